// File: rtl/soc_sysid_checker.sv
// soc_sysid_checker
// Reads the two sysid words (ID, then build timestamp) through a single
// address/readdata slave port, compares them against the values this build
// expects and reports the result. A check is started by 'start' or, once
// after each reset, automatically when AUTO_START = 1.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start / auto-start arm
// RD_ID  | address = 0, wait READ_LATENCY cycles, capture ID word
// RD_TS  | address = 1, wait READ_LATENCY cycles, capture timestamp
// CMP    | compare captured words, pulse done, update fail_count

module soc_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'h00000000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1672894844,
    parameter int          READ_LATENCY       = 0,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        sysid_address,
    input  logic [31:0] sysid_readdata,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        match,
    output logic [7:0]  fail_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RD_ID = 2'd1,
        S_RD_TS = 2'd2,
        S_CMP   = 2'd3
    } state_t;

    // The wait counter is 2 bits wide, so only latencies 0..3 are meaningful.
    localparam logic [1:0] LAT = READ_LATENCY[1:0];

    state_t      state;
    state_t      next_state;
    logic [1:0]  wait_cnt;
    logic        arm;

    logic        accept;
    logic        lat_hit;
    logic        id_eq;
    logic        ts_eq;

    logic [1:0]  wait_cnt_d;
    logic        arm_d;
    logic        sysid_address_d;
    logic        busy_d;
    logic        done_d;
    logic        valid_d;
    logic [31:0] id_value_d;
    logic [31:0] ts_value_d;
    logic        id_ok_d;
    logic        ts_ok_d;
    logic        match_d;
    logic [7:0]  fail_count_d;

    assign accept  = (state == S_IDLE) && (start || (AUTO_START && arm));
    assign lat_hit = (wait_cnt == LAT);
    assign id_eq   = (id_value == EXPECTED_ID);
    assign ts_eq   = (ts_value == EXPECTED_TIMESTAMP);

    // State register; reset aborts any check in progress on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (accept)  next_state = S_RD_ID;
            S_RD_ID: if (lat_hit) next_state = S_RD_TS;
            S_RD_TS: if (lat_hit) next_state = S_CMP;
            S_CMP:                next_state = S_IDLE;
            default:              next_state = S_IDLE;
        endcase
    end

    // Next values of every registered output; derived from next_state so the
    // flops line up with the state they describe.
    always_comb begin
        sysid_address_d = (next_state == S_RD_TS);
        busy_d          = (next_state != S_IDLE);
        done_d          = (state == S_CMP);
        arm_d           = arm & ~accept;
        valid_d         = valid;
        id_value_d      = id_value;
        ts_value_d      = ts_value;
        id_ok_d         = id_ok;
        ts_ok_d         = ts_ok;
        match_d         = match;
        fail_count_d    = fail_count;

        // Counter restarts on every state change and counts within a read state.
        if (next_state != state) begin
            wait_cnt_d = 2'd0;
        end else if (state == S_RD_ID || state == S_RD_TS) begin
            wait_cnt_d = wait_cnt + 2'd1;
        end else begin
            wait_cnt_d = 2'd0;
        end

        if (accept) begin
            valid_d = 1'b0;
        end

        if (state == S_RD_ID && lat_hit) begin
            id_value_d = sysid_readdata;
        end

        if (state == S_RD_TS && lat_hit) begin
            ts_value_d = sysid_readdata;
        end

        if (state == S_CMP) begin
            id_ok_d = id_eq;
            ts_ok_d = ts_eq;
            match_d = id_eq & ts_eq;
            valid_d = 1'b1;
            if (!(id_eq && ts_eq) && fail_count != 8'hFF) begin
                fail_count_d = fail_count + 8'd1;
            end
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt      <= 2'd0;
            arm           <= AUTO_START;
            sysid_address <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            valid         <= 1'b0;
            id_value      <= 32'd0;
            ts_value      <= 32'd0;
            id_ok         <= 1'b0;
            ts_ok         <= 1'b0;
            match         <= 1'b0;
            fail_count    <= 8'd0;
        end else begin
            wait_cnt      <= wait_cnt_d;
            arm           <= arm_d;
            sysid_address <= sysid_address_d;
            busy          <= busy_d;
            done          <= done_d;
            valid         <= valid_d;
            id_value      <= id_value_d;
            ts_value      <= ts_value_d;
            id_ok         <= id_ok_d;
            ts_ok         <= ts_ok_d;
            match         <= match_d;
            fail_count    <= fail_count_d;
        end
    end

endmodule

// File: tb/tb_soc_sysid_checker.sv
// Directed bench for soc_sysid_checker: one instance with zero read latency
// and auto-start, one with two cycles of read latency and no auto-start.
`timescale 1ns/1ps

module tb_soc_sysid_checker;

    localparam logic [31:0] GOOD_TS = 32'd1672894844;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Instance A: READ_LATENCY = 0, AUTO_START = 1
    logic        rst_a = 1'b1;
    logic        start_a = 1'b0;
    logic        addr_a;
    logic [31:0] rdata_a;
    logic        busy_a, done_a, valid_a, id_ok_a, ts_ok_a, match_a;
    logic [31:0] idv_a, tsv_a;
    logic [7:0]  fail_a;
    logic [31:0] slave_id_a = 32'h0;
    logic [31:0] slave_ts_a = GOOD_TS;

    assign rdata_a = addr_a ? slave_ts_a : slave_id_a;

    soc_sysid_checker #(.READ_LATENCY(0), .AUTO_START(1'b1)) dut_a (
        .clock(clk), .reset(rst_a), .start(start_a),
        .sysid_address(addr_a), .sysid_readdata(rdata_a),
        .busy(busy_a), .done(done_a), .valid(valid_a),
        .id_value(idv_a), .ts_value(tsv_a),
        .id_ok(id_ok_a), .ts_ok(ts_ok_a), .match(match_a),
        .fail_count(fail_a)
    );

    // Instance B: READ_LATENCY = 2, AUTO_START = 0. The slave model returns
    // real data only once the address has been stable for two cycles.
    logic        rst_b = 1'b1;
    logic        start_b = 1'b0;
    logic        addr_b, addr_b_d1, addr_b_d2;
    logic [31:0] rdata_b;
    logic        busy_b, done_b, valid_b, id_ok_b, ts_ok_b, match_b;
    logic [31:0] idv_b, tsv_b;
    logic [7:0]  fail_b;
    logic [31:0] slave_id_b = 32'h0;
    logic [31:0] slave_ts_b = 32'h12345678;

    always @(posedge clk) begin
        addr_b_d1 <= addr_b;
        addr_b_d2 <= addr_b_d1;
    end

    assign rdata_b = (addr_b == addr_b_d1 && addr_b_d1 == addr_b_d2)
                     ? (addr_b ? slave_ts_b : slave_id_b) : 32'hDEADBEEF;

    soc_sysid_checker #(.READ_LATENCY(2), .AUTO_START(1'b0)) dut_b (
        .clock(clk), .reset(rst_b), .start(start_b),
        .sysid_address(addr_b), .sysid_readdata(rdata_b),
        .busy(busy_b), .done(done_b), .valid(valid_b),
        .id_value(idv_b), .ts_value(tsv_b),
        .id_ok(id_ok_b), .ts_ok(ts_ok_b), .match(match_b),
        .fail_count(fail_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns the index (0-based, counted from the next rising edge) of the
    // edge after which done_a is seen high, or -1 on timeout.
    task automatic wait_done_a(input int maxc, output int idx);
        idx = -1;
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk); #1;
            if (done_a) begin
                idx = i;
                break;
            end
        end
    endtask

    task automatic wait_done_b(input int maxc, output int idx);
        idx = -1;
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk); #1;
            if (done_b) begin
                idx = i;
                break;
            end
        end
    endtask

    int idx;
    int dcount;
    int dcycle;
    int ndone;

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  32'(busy_a),  32'd0);
        check("rst_done",  32'(done_a),  32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_match", 32'(match_a), 32'd0);
        check("rst_addr",  32'(addr_a),  32'd0);
        check("rst_fail",  32'(fail_a),  32'd0);
        check("rst_idv",   idv_a,        32'd0);

        // ---------------- auto-start after reset release, L=0 ----------------
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        wait_done_a(20, idx);
        check("auto_latency", 32'(idx), 32'd3);
        check("auto_match",   32'(match_a), 32'd1);
        check("auto_valid",   32'(valid_a), 32'd1);
        check("auto_fail",    32'(fail_a),  32'd0);
        check("auto_tsv",     tsv_a,        GOOD_TS);
        check("auto_busy",    32'(busy_a),  32'd0);
        @(posedge clk); #1;
        check("auto_done_1cyc", 32'(done_a), 32'd0);
        check("auto_no_rerun",  32'(busy_a), 32'd0);

        // ---------------- start held high: back-to-back checks ----------------
        @(negedge clk);
        start_a = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            check($sformatf("b2b_done_%0d", i), 32'(done_a), 32'((i % 4) == 0));
            check($sformatf("b2b_busy_%0d", i), 32'(busy_a), 32'((i % 4) != 0));
            check($sformatf("b2b_addr_%0d", i), 32'(addr_a), 32'((i % 4) == 2));
        end
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("b2b_idle_busy", 32'(busy_a),  32'd0);
        check("b2b_match",     32'(match_a), 32'd1);

        // ---------------- start pulse during RD_TS is ignored ----------------
        dcount = 0;
        dcycle = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            start_a = (i == 1 || i == 3);
            @(posedge clk); #1;
            if (i == 3) check("ign_busy_rdts", 32'(busy_a), 32'd1);
            if (done_a) begin
                dcount++;
                dcycle = i;
            end
        end
        @(negedge clk);
        start_a = 1'b0;
        check("ign_done_count", 32'(dcount), 32'd1);
        check("ign_done_cycle", 32'(dcycle), 32'd4);

        // ---------------- reset during RD_TS ----------------
        slave_id_a = 32'hCAFE0001;   // would make the aborted check mismatch
        start_a = 1'b1;
        @(negedge clk);              // edge 1 accepts start
        start_a = 1'b0;
        @(negedge clk);              // edge 2 moves to RD_TS
        rst_a = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_done",  32'(done_a),  32'd0);
        check("rst_mid_busy",  32'(busy_a),  32'd0);
        check("rst_mid_valid", 32'(valid_a), 32'd0);
        check("rst_mid_idv",   idv_a,        32'd0);
        check("rst_mid_addr",  32'(addr_a),  32'd0);
        @(posedge clk); #1;
        check("rst_mid_nodone", 32'(done_a), 32'd0);
        @(negedge clk);
        slave_id_a = 32'h0;
        rst_a = 1'b0;
        wait_done_a(20, idx);
        check("rearm_latency", 32'(idx),     32'd3);
        check("rearm_match",   32'(match_a), 32'd1);
        check("rearm_fail",    32'(fail_a),  32'd0);

        // ---------------- fail_count saturation ----------------
        @(negedge clk);
        slave_id_a = 32'h00000001;
        start_a = 1'b1;
        ndone = 0;
        for (int i = 0; i < 1400 && ndone < 300; i++) begin
            @(posedge clk); #1;
            if (done_a) begin
                ndone++;
                if (ndone == 1) begin
                    check("sat_first_fail", 32'(fail_a),  32'd1);
                    check("sat_first_idok", 32'(id_ok_a), 32'd0);
                    check("sat_first_tsok", 32'(ts_ok_a), 32'd1);
                    check("sat_first_match", 32'(match_a), 32'd0);
                end
                if (ndone == 254) check("sat_254", 32'(fail_a), 32'd254);
                if (ndone == 255) check("sat_255", 32'(fail_a), 32'd255);
                if (ndone == 256) check("sat_256", 32'(fail_a), 32'd255);
            end
        end
        @(negedge clk);
        start_a = 1'b0;
        check("sat_count_done", 32'(ndone),  32'd300);
        check("sat_final",      32'(fail_a), 32'd255);

        // ---------------- instance B: latency 2, timestamp mismatch ----------------
        check("b_no_autostart", 32'(busy_b), 32'd0);
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_done_b(30, idx);
        check("b_latency", 32'(idx + 1), 32'd7);
        check("b_idok",    32'(id_ok_b), 32'd1);
        check("b_tsok",    32'(ts_ok_b), 32'd0);
        check("b_match",   32'(match_b), 32'd0);
        check("b_fail",    32'(fail_b),  32'd1);
        check("b_tsv",     tsv_b,        32'h12345678);
        check("b_idv",     idv_b,        32'h0);
        check("b_valid",   32'(valid_b), 32'd1);

        // Second B check with the correct timestamp: valid drops while running.
        @(negedge clk);
        slave_ts_b = GOOD_TS;
        start_b = 1'b1;
        @(posedge clk); #1;
        check("b2_valid_running", 32'(valid_b), 32'd0);
        check("b2_match_held",    32'(match_b), 32'd0);
        @(negedge clk);
        start_b = 1'b0;
        wait_done_b(30, idx);
        check("b2_latency", 32'(idx + 1), 32'd7);
        check("b2_match",   32'(match_b), 32'd1);
        check("b2_fail",    32'(fail_b),  32'd1);
        check("b2_tsv",     tsv_b,        GOOD_TS);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
